// File: rtl/imips_pkg.sv
// rtl/imips_pkg.sv - sequencer state encoding and instruction field positions
package imips_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT_IN = 3'd3,
    S_HALT    = 3'd4,
    S_STOP    = 3'd5
  } seq_state_t;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int FUNCT_HI = 4;
  localparam int FUNCT_LO = 0;
  localparam int OFFS_W   = 16;

  // Low instruction bits the next-PC logic looks at: jump target and branch offset.
  function automatic int ir_low_w(input int addr_w);
    return (addr_w > OFFS_W) ? addr_w : OFFS_W;
  endfunction

endpackage

// File: rtl/instr_sequencer_pc_next.sv
// rtl/instr_sequencer_pc_next.sv - combinational next-PC and link address selection
module pc_next
  import imips_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int IR_W   = ir_low_w(ADDR_W)
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [IR_W-1:0]   ir_i,
  input  logic              jump_i,
  input  logic              branch_i,
  input  logic              cond_i,
  input  logic              jump_r_i,
  input  logic              flag_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] link_pc_o
);

  logic              taken;
  logic [ADDR_W-1:0] offs;

  assign taken     = !cond_i || flag_i;
  // Sign-extending cast also truncates when the address is narrower than the offset.
  assign offs      = ADDR_W'($signed(ir_i[OFFS_W-1:0]));
  assign link_pc_o = pc_i + ADDR_W'(1);

  always_comb begin
    next_pc_o = link_pc_o;
    if (jump_r_i) begin
      next_pc_o = jr_target_i;
    end else if (jump_i && taken) begin
      next_pc_o = ir_i[ADDR_W-1:0];
    end else if (branch_i && taken) begin
      next_pc_o = link_pc_o + offs;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/exec sequencer holding pc and ir, with input/halt/stop stalls
module instr_sequencer
  import imips_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       ir,
  output logic [5:0]        opcode,
  output logic [4:0]        funct,
  input  logic              jump,
  input  logic              branch,
  input  logic              cond,
  input  logic              jumpR,
  input  logic              sleep,
  input  logic              haltOp,
  input  logic              inop,
  input  logic              flag,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              in_valid,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic              exec_en,
  output logic              halted,
  output logic              stopped,
  output logic [2:0]        state_o
);

  localparam int IR_W = ir_low_w(ADDR_W);

  seq_state_t        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [ADDR_W-1:0] next_pc;

  pc_next #(
    .ADDR_W (ADDR_W),
    .IR_W   (IR_W)
  ) u_pc_next (
    .pc_i        (pc_q),
    .ir_i        (ir_q[IR_W-1:0]),
    .jump_i      (jump),
    .branch_i    (branch),
    .cond_i      (cond),
    .jump_r_i    (jumpR),
    .flag_i      (flag),
    .jr_target_i (jr_target),
    .next_pc_o   (next_pc),
    .link_pc_o   (link_pc)
  );

  // The strobes come from the current ir in the same cycle, so the qualifier is decided combinationally.
  always_comb begin
    exec_en = 1'b0;
    case (state_q)
      S_EXEC:    exec_en = !sleep && (haltOp || !inop || in_valid);
      S_WAIT_IN: exec_en = in_valid;
      default:   exec_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= BOOT_ADDR;
      ir_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= instr;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (sleep) begin
            state_q <= S_STOP;
          end else if (haltOp) begin
            pc_q    <= link_pc;
            state_q <= S_HALT;
          end else if (inop && !in_valid) begin
            state_q <= S_WAIT_IN;
          end else begin
            pc_q    <= next_pc;
            state_q <= S_FETCH;
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            pc_q    <= link_pc;
            state_q <= S_FETCH;
          end
        end
        S_HALT: begin
          if (resume) begin
            state_q <= S_FETCH;
          end
        end
        S_STOP:  state_q <= S_STOP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[OPC_HI:OPC_LO];
  assign funct     = ir_q[FUNCT_HI:FUNCT_LO];
  assign halted    = (state_q == S_HALT);
  assign stopped   = (state_q == S_STOP);
  assign state_o   = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a toy decoder and memory
module tb_instr_sequencer;

  localparam int AW = 10;
  localparam logic [2:0] ST_FETCH = 3'd0, ST_EXEC = 3'd2, ST_WAIT = 3'd3,
                         ST_HALT = 3'd4, ST_STOP = 3'd5;
  localparam logic [5:0] OP_NOP = 6'd0, OP_J = 6'd1, OP_JC = 6'd2, OP_BR = 6'd3,
                         OP_JR = 6'd5, OP_SLEEP = 6'd6, OP_HALT = 6'd7, OP_INOP = 6'd8;

  typedef struct {
    logic [AW-1:0] pc;
    logic [2:0]    st;
    logic [5:0]    op;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [AW-1:0] mon_lk;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instr;
  logic [AW-1:0] imem_addr;
  logic [31:0]   ir_w;
  logic [5:0]    opcode_w;
  logic [4:0]    funct_w;
  logic          jump, branch, cond, jump_r, sleep, halt_op, inop;
  logic          flag = 1'b0;
  logic [AW-1:0] jr_target = '0;
  logic          in_valid = 1'b0;
  logic          resume = 1'b0;
  logic [AW-1:0] pc_w, link_pc_w;
  logic          exec_en, halted, stopped;
  logic [2:0]    state_w;

  logic [31:0] mem [0:(1<<AW)-1];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_on = 1'b0;
  int pulses;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(AW), .BOOT_ADDR(10'd0)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_addr(imem_addr), .ir(ir_w),
    .opcode(opcode_w), .funct(funct_w), .jump(jump), .branch(branch), .cond(cond),
    .jumpR(jump_r), .sleep(sleep), .haltOp(halt_op), .inop(inop), .flag(flag),
    .jr_target(jr_target), .in_valid(in_valid), .resume(resume), .pc(pc_w),
    .link_pc(link_pc_w), .exec_en(exec_en), .halted(halted), .stopped(stopped),
    .state_o(state_w)
  );

  always @(posedge clk) instr <= mem[imem_addr];

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always_comb begin
    jump    = (ir_w[31:26] == OP_J) || (ir_w[31:26] == OP_JC);
    cond    = (ir_w[31:26] == OP_JC);
    branch  = (ir_w[31:26] == OP_BR);
    jump_r  = (ir_w[31:26] == OP_JR);
    sleep   = (ir_w[31:26] == OP_SLEEP);
    halt_op = (ir_w[31:26] == OP_HALT);
    inop    = (ir_w[31:26] == OP_INOP);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && rst_n && exec_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_exec: got pc %0h want no exec", pc_w);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_lk = mon_e.pc + 10'd1;
        check("exec_pc", {22'd0, pc_w}, {22'd0, mon_e.pc});
        check("exec_link", {22'd0, link_pc_w}, {22'd0, mon_lk});
        check("exec_state", {29'd0, state_w}, {29'd0, mon_e.st});
        check("exec_opcode", {26'd0, opcode_w}, {26'd0, mon_e.op});
        if (mon_e.cyc != 0) check("exec_cycle", cyc + 1, mon_e.cyc);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] low);
    return {op, 10'd0, low};
  endfunction

  task automatic push(input int p, input logic [2:0] st, input logic [5:0] op, input int c);
    exp_t e;
    e.pc  = p[AW-1:0];
    e.st  = st;
    e.op  = op;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_nops(input int first, input int last);
    for (int i = first; i <= last; i++) push(i, ST_EXEC, OP_NOP, 0);
  endtask

  task automatic rst_begin();
    mon_on = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    in_valid  = 1'b0;
    resume    = 1'b0;
    flag      = 1'b0;
    jr_target = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
  endtask

  task automatic rst_end();
    @(negedge clk);
    check("rst_pc", {22'd0, pc_w}, 32'd0);
    check("rst_ir", ir_w, 32'd0);
    check("rst_exec_en", {31'd0, exec_en}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_stopped", {31'd0, stopped}, 32'd0);
    check("rst_state", {29'd0, state_w}, {29'd0, ST_FETCH});
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    for (int i = 0; i < 400 && state_w !== st; i++) @(negedge clk);
    check(name, {29'd0, state_w}, {29'd0, st});
  endtask

  initial begin
    // Straight-line NOPs: one exec every 3 cycles starting at cycle 3.
    rst_begin();
    rst_end();
    for (int i = 0; i < 5; i++) push(i, ST_EXEC, OP_NOP, 3 * (i + 1));
    drain("straight_drain");

    // Conditional jump at pc 5, not taken then taken.
    rst_begin();
    mem[5] = mk(OP_JC, 16'h02A0);
    rst_end();
    push_nops(0, 4);
    push(5, ST_EXEC, OP_JC, 0);
    push(6, ST_EXEC, OP_NOP, 0);
    drain("jc_nt_drain");

    rst_begin();
    mem[5] = mk(OP_JC, 16'h02A0);
    flag = 1'b1;
    rst_end();
    push_nops(0, 4);
    push(5, ST_EXEC, OP_JC, 0);
    push(10'h2A0, ST_EXEC, OP_NOP, 0);
    drain("jc_t_drain");

    // Backward branch 3+1-4 = 0.
    rst_begin();
    mem[3] = mk(OP_BR, 16'hFFFC);
    rst_end();
    push_nops(0, 2);
    push(3, ST_EXEC, OP_BR, 0);
    push_nops(0, 1);
    drain("br_back_drain");

    // Branch with zero offset from the top address wraps to 0.
    rst_begin();
    mem[0]    = mk(OP_J, 16'h03FF);
    mem[1023] = mk(OP_BR, 16'h0000);
    rst_end();
    push(0, ST_EXEC, OP_J, 0);
    push(1023, ST_EXEC, OP_BR, 0);
    push(0, ST_EXEC, OP_J, 0);
    drain("br_wrap_drain");

    // Register jump.
    rst_begin();
    mem[0] = mk(OP_JR, 16'h0000);
    jr_target = 10'h155;
    rst_end();
    push(0, ST_EXEC, OP_JR, 0);
    push(10'h155, ST_EXEC, OP_NOP, 0);
    drain("jr_drain");

    // Input stall at pc 8, then same-cycle in_valid at pc 10.
    rst_begin();
    mem[8]  = mk(OP_INOP, 16'h0000);
    mem[10] = mk(OP_INOP, 16'h0000);
    rst_end();
    push_nops(0, 7);
    wait_state(ST_WAIT, "reach_wait_in");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("wait_exec_en", {31'd0, exec_en}, 32'd0);
      check("wait_pc", {22'd0, pc_w}, 32'd8);
      check("wait_state", {29'd0, state_w}, {29'd0, ST_WAIT});
    end
    push(8, ST_WAIT, OP_INOP, 0);
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("wait_exit_pc", {22'd0, pc_w}, 32'd9);
    check("wait_exit_state", {29'd0, state_w}, {29'd0, ST_FETCH});
    push(9, ST_EXEC, OP_NOP, 0);
    push(10, ST_EXEC, OP_INOP, 0);
    push(11, ST_EXEC, OP_NOP, 0);
    @(posedge clk);
    #1 in_valid = 1'b1;
    drain("inop_nostall_drain");
    in_valid = 1'b0;

    // Halt at pc 12; early resume pulses must not disturb execution.
    rst_begin();
    mem[12] = mk(OP_HALT, 16'h0013);
    rst_end();
    resume = 1'b1;
    push_nops(0, 11);
    push(12, ST_EXEC, OP_HALT, 0);
    repeat (6) @(posedge clk);
    #1 resume = 1'b0;
    wait_state(ST_HALT, "reach_halt");
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_pc", {22'd0, pc_w}, 32'd13);
    check("halt_funct", {27'd0, funct_w}, 32'h13);
    check("halt_stopped", {31'd0, stopped}, 32'd0);
    check("halt_drain", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    check("halt_hold", {31'd0, halted}, 32'd1);
    push(13, ST_EXEC, OP_NOP, 0);
    @(posedge clk);
    #1 resume = 1'b1;
    @(posedge clk);
    #1 resume = 1'b0;
    drain("resume_drain");
    check("resume_halted", {31'd0, halted}, 32'd0);

    // Sleep at pc 20, then asynchronous reset while stopped.
    rst_begin();
    mem[20] = mk(OP_SLEEP, 16'h0000);
    rst_end();
    push_nops(0, 19);
    wait_state(ST_STOP, "reach_stop");
    check("stop_stopped", {31'd0, stopped}, 32'd1);
    check("stop_pc", {22'd0, pc_w}, 32'd20);
    check("stop_drain", exp_q.size(), 32'd0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exec_en) pulses++;
    end
    check("stop_no_exec", pulses, 32'd0);
    check("stop_hold", {31'd0, stopped}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pc", {22'd0, pc_w}, 32'd0);
    check("async_rst_ir", ir_w, 32'd0);
    check("async_rst_stopped", {31'd0, stopped}, 32'd0);
    check("async_rst_state", {29'd0, state_w}, {29'd0, ST_FETCH});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/sequencing stage that feeds the control unit: holds the program counter and instruction register, and drives opcode/funct from the registered instruction. It consumes the decoder's flow-control strobes (jump, branch, cond, jumpR, sleep, haltOp, inop) to compute the next PC. It stalls on input, halt and stop, and produces the one-cycle `exec_en` strobe that gates every architectural write in the datapath.

## Interface
- `ADDR_W`, 10, instruction-memory address width
- `BOOT_ADDR`, 0, PC value after reset
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `instr` in 32, instruction-memory read data (synchronous read, 1-cycle latency)
- `imem_addr` out ADDR_W, instruction-memory address (= `pc`)
- `ir` out 32, registered instruction
- `opcode` out 6, `ir[31:26]`
- `funct` out 5, `ir[4:0]`
- `jump`, `branch`, `cond`, `jumpR`, `sleep`, `haltOp`, `inop` in 1 each, decoder strobes for current `ir`
- `flag` in 1, ALU condition result
- `jr_target` in ADDR_W, register-file value for jumpR
- `in_valid` in 1, one-cycle pulse: input data confirmed
- `resume` in 1, one-cycle pulse: leave HALT
- `pc` out ADDR_W, current program counter
- `link_pc` out ADDR_W, `pc+1` mod 2^ADDR_W (for jal/bal)
- `exec_en` out 1, write-enable qualifier for the current instruction
- `halted`, `stopped` out 1 each, status in HALT / STOP
- `state_o` out 3, FSM state (debug)

## Operation
- States: FETCH, DECODE, EXEC, WAIT_IN, HALT, STOP.
- FETCH: memory samples `imem_addr`; go DECODE.
- DECODE: `ir <= instr`; go EXEC.
- EXEC: decoder drives strobes from `ir`; one-cycle decision, first match wins:
  - `sleep` -> STOP, `exec_en=0`, pc unchanged.
  - `haltOp` -> HALT, `exec_en=1`, `pc <= pc+1`.
  - `inop && !in_valid` -> WAIT_IN, `exec_en=0`, pc unchanged.
  - Otherwise `exec_en=1`, go FETCH, pc updated per the next-PC rule.
- Next-PC rule: `taken = !cond || flag`. Evaluated in this order:
  - `jumpR` -> `jr_target`.
  - `jump && taken` -> `ir[ADDR_W-1:0]`.
  - `branch && taken` -> `pc + 1 + sext(ir[15:0])`.
  - else -> `pc+1`.
- Arithmetic: all PC math is mod 2^ADDR_W. The 16-bit offset is sign-extended/truncated to ADDR_W.
- WAIT_IN: `exec_en=0` until `in_valid`. On that cycle: `exec_en=1`, `pc <= pc+1`, go FETCH.
- HALT: holds until `resume`, then go FETCH. `halted=1` throughout.
- STOP: terminal until reset. `stopped=1`. `exec_en=0`.
- Ignored inputs: `in_valid` outside EXEC/WAIT_IN; `resume` outside HALT.

## Timing
- Reset (async, asserted): `pc=BOOT_ADDR`, `ir=0` (opcode 0 decodes to NOP), `exec_en=0`, `halted=0`, `stopped=0`, state FETCH.
- Reset deasserted: first fetch is issued in the first cycle after release.
- CPI: 3 cycles (FETCH, DECODE, EXEC) with no stall. `exec_en` is high only in the EXEC or WAIT_IN exit cycle.
- Register updates: `pc` and `ir` change only on the clock edge ending EXEC/WAIT_IN (pc) or DECODE (ir). `ir` is stable for the whole EXEC/WAIT_IN/HALT/STOP period.
- `in_valid` in the same EXEC cycle as `inop`: no stall; completes in 3 cycles.
- Reset mid-stall (any state): immediate return to the reset values above.
- `pc = 2^ADDR_W-1` with sequential flow: next pc = 0. `link_pc` likewise wraps.
- `opcode`, `funct`, `link_pc`, `halted`, `stopped`, `state_o`: combinational from registers, glitch-free relative to `clk`.

## Structure
- Shared package `imips_pkg` holds:
  - state enum `seq_state_t`;
  - instruction field constants: OPC_HI=31, OPC_LO=26, FUNCT_HI=4, FUNCT_LO=0, OFFS_W=16.
- One sub-module: `pc_next`, purely combinational. Inputs: pc, ir, strobes, flag, jr_target. Outputs: next_pc, link_pc.
- The FSM and registers live in `instr_sequencer`.

## Test plan
- Straight-line: reset with BOOT_ADDR=0, memory holds NOPs. Expect pc 0,1,2 at cycles 3,6,9, and exactly one `exec_en` pulse per 3 cycles.
- Conditional jump at pc=5, `ir[9:0]=0x2A0`, cond=1:
  - flag=0 -> next pc=6;
  - flag=1 -> next pc=0x2A0.
- Branch, ADDR_W=10:
  - at pc=3, offset 0xFFFC -> pc=0 (3+1-4);
  - at pc=1023, offset 0 -> pc=0 (wrap).
- inop at pc=8: hold `in_valid=0` for 20 cycles. Expect WAIT_IN, `exec_en=0`, pc=8. Pulse `in_valid`: `exec_en=1` that cycle, pc=9, FETCH next.
- haltOp at pc=12: `halted=1` and pc=13. `resume` pulse -> FETCH of 13. `resume` pulses while in FETCH/EXEC have no effect.
- sleep at pc=20: STOP, `stopped=1`, no further `exec_en` for 100 cycles. Assert `rst_n=0` mid-STOP -> pc=BOOT_ADDR, ir=0, `stopped=0`, asynchronously.
